// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES types, constants and byte/block transforms used by
//            the AES-256 encryption and decryption cores.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [127:0] block_t;
    typedef logic [255:0] key_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2
    } dec_state_e;

    // Round constants, indexed by round-key-pair number (entry 0 unused)
    localparam logic [7:0][7:0] RCON = {8'h40, 8'h20, 8'h10, 8'h08,
                                        8'h04, 8'h02, 8'h01, 8'h00};

    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [0:255][7:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[b];
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant (0x9, 0xb, 0xd, 0xe in practice)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
               (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

    // Byte i of a block sits at row i%4, column i/4; byte 0 is the MSB
    function automatic block_t inv_shift_rows(input block_t s);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic block_t inv_sub_bytes(input block_t s);
        block_t o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i+7 -: 8] = inv_sbox(s[8*i+7 -: 8]);
        end
        return o;
    endfunction

    function automatic block_t inv_mix_columns(input block_t s);
        block_t     o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0,4'he) ^ gf_mul(a1,4'hb) ^ gf_mul(a2,4'hd) ^ gf_mul(a3,4'h9);
            o[119-32*c -: 8] = gf_mul(a0,4'h9) ^ gf_mul(a1,4'he) ^ gf_mul(a2,4'hb) ^ gf_mul(a3,4'hd);
            o[111-32*c -: 8] = gf_mul(a0,4'hd) ^ gf_mul(a1,4'h9) ^ gf_mul(a2,4'he) ^ gf_mul(a3,4'hb);
            o[103-32*c -: 8] = gf_mul(a0,4'hb) ^ gf_mul(a1,4'hd) ^ gf_mul(a2,4'h9) ^ gf_mul(a3,4'he);
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_round
// Brief    : One combinational AES inverse round; the final round skips
//            InvMixColumns.
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] next_state
);

    block_t w_keyed;

    // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last
    always_comb begin
        w_keyed    = inv_sub_bytes(inv_shift_rows(state)) ^ rk;
        next_state = last ? w_keyed : inv_mix_columns(w_keyed);
    end

endmodule
`default_nettype wire

// File: rtl/aes_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt_core
// Brief    : Iterative AES-256 ECB inverse cipher. Expands the key once into
//            a 15-entry round-key file, then runs one inverse round per clock.
// Revision : 1.0 - initial release
// ============================================================================
module aes_decrypt_core
    import aes_pkg::*;
#(
    parameter int NR = 14,
    parameter int NK = 8
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             new_key_i,
    input  logic [32*NK-1:0] key_i,
    input  logic [127:0]     ciphertext_i,
    output logic [127:0]     plaintext_o,
    output logic             done_o,
    output logic             ready_o
);

    dec_state_e r_fsm, w_fsm_nxt;
    block_t     r_rk [0:NR];
    block_t     r_ct, r_blk, w_round_out, w_new_rk, w_prev1, w_prev2;
    word_t      w_t, w_w0, w_w1, w_w2, w_w3;
    logic [3:0] r_rnd, r_kcnt;
    logic       r_key_valid;
    logic       w_accept, w_load_key, w_kexp_last, w_finish;

    // Round-key generator: round key kcnt from round keys kcnt-2 and kcnt-1
    always_comb begin
        w_prev2 = r_rk[r_kcnt - 4'd2];
        w_prev1 = r_rk[r_kcnt - 4'd1];
        if (r_kcnt[0]) begin
            w_t = sub_word(w_prev1[31:0]);
        end else begin
            w_t = sub_word(rot_word(w_prev1[31:0])) ^ {RCON[r_kcnt[3:1]], 24'h0};
        end
        w_w0     = w_prev2[127:96] ^ w_t;
        w_w1     = w_prev2[95:64]  ^ w_w0;
        w_w2     = w_prev2[63:32]  ^ w_w1;
        w_w3     = w_prev2[31:0]   ^ w_w2;
        w_new_rk = {w_w0, w_w1, w_w2, w_w3};
    end

    aes_inv_round u_inv_round (
        .state      (r_blk),
        .rk         (r_rk[r_rnd]),
        .last       (r_rnd == 4'd0),
        .next_state (w_round_out)
    );

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_fsm <= IDLE;
        else       r_fsm <= w_fsm_nxt;
    end

    // Next-state decode and control strobes
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_accept    = 1'b0;
        w_load_key  = 1'b0;
        w_kexp_last = 1'b0;
        w_finish    = 1'b0;
        ready_o     = (r_fsm == IDLE);
        case (r_fsm)
            IDLE: begin
                if (start_i) begin
                    w_accept = 1'b1;
                    if (new_key_i || !r_key_valid) begin
                        w_load_key = 1'b1;
                        w_fsm_nxt  = KEYEXP;
                    end else begin
                        w_fsm_nxt  = ROUND;
                    end
                end
            end
            KEYEXP: begin
                if (r_kcnt == 4'(NR)) begin
                    w_kexp_last = 1'b1;
                    w_fsm_nxt   = ROUND;
                end
            end
            ROUND: begin
                if (r_rnd == 4'd0) begin
                    w_finish  = 1'b1;
                    w_fsm_nxt = IDLE;
                end
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // Round-key file: deliberately not reset, only written during loading
    always_ff @(posedge clk_i) begin
        if (w_load_key) begin
            r_rk[0] <= key_i[32*NK-1 -: 128];
            r_rk[1] <= key_i[127:0];
        end
        if (r_fsm == KEYEXP) begin
            r_rk[r_kcnt] <= w_new_rk;
        end
    end

    // Datapath: input latch, round state, counters and result register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ct        <= '0;
            r_blk       <= '0;
            r_rnd       <= 4'd0;
            r_kcnt      <= 4'd0;
            r_key_valid <= 1'b0;
            plaintext_o <= '0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (w_accept) begin
                r_ct <= ciphertext_i;
                if (w_load_key) begin
                    r_kcnt      <= 4'd2;
                    r_key_valid <= 1'b0;
                end else begin
                    r_blk <= ciphertext_i ^ r_rk[NR];
                    r_rnd <= 4'(NR - 1);
                end
            end
            if (r_fsm == KEYEXP) begin
                r_kcnt <= r_kcnt + 4'd1;
                if (w_kexp_last) begin
                    r_key_valid <= 1'b1;
                    r_blk       <= r_ct ^ w_new_rk;
                    r_rnd       <= 4'(NR - 1);
                end
            end
            if (r_fsm == ROUND) begin
                r_blk <= w_round_out;
                r_rnd <= r_rnd - 4'd1;
                if (w_finish) begin
                    plaintext_o <= w_round_out;
                    done_o      <= 1'b1;
                    r_rnd       <= 4'd0;
                end
            end
        end
    end

endmodule
`default_nettype wire
